fm_demod_front: RTL and testbench
=================================

// Module: fm_demod_front
// PURPOSE
//  FM discriminator front end. Pops complex baseband samples (I/Q, Q10) from the channel-filter FIFO.
//  Forms the conjugate product cur*conj(prev) and hands (x=real, y=imag) to the qarctan stage.
//  Scales the returned angle by the demod gain and pushes one real sample to the audio-filter FIFO.
//  Sits between the channel FIR output FIFO and the qarctan block.
// PARAMETERS
//  DATA_WIDTH  32   sample/angle width, signed Q10
//  BITS        10   fixed-point fraction bits used for every DEQUANTIZE
//  GAIN        758  demod gain, Q10 (quad_rate/(2*pi*max_dev) = 0.7407)
// PORTS
//  clk             in   1   single clock
//  reset_n         in   1   asynchronous, active-low reset
//  in_empty        in   1   upstream FIFO empty
//  in_rd_en        out  1   pop strobe; one cycle per sample
//  in_real         in   32  current I, valid with !in_empty
//  in_imag         in   32  current Q
//  demod_data_valid out 1   one-cycle start pulse to qarctan
//  x               out  32  real part of conjugate product; held stable from pulse until done
//  y               out  32  imag part of conjugate product; same hold rule
//  qarctan_data_out in  32  angle, Q10 radians
//  qarctan_done    in   1   angle valid this cycle
//  out_full        in   1   downstream FIFO full
//  out_wr_en       out  1   push strobe
//  out_dout        out  32  demodulated sample, Q10
// BEHAVIOUR
//  Reset (reset_n=0, async): state=S_IDLE; prev_real=prev_imag=0; x=y=0.
//   All strobes (in_rd_en, demod_data_valid, out_wr_en) and out_dout are 0.
//  DEQ(v): (v<0 ? v+(2^BITS-1) : v) >>> BITS, i.e. round toward zero. Every product keeps the low 32 bits first.
//  FSM:
//   S_IDLE : if !in_empty -> in_rd_en=1; latch cur=(in_real,in_imag) -> S_MULT.
//   S_MULT : r = DEQ(prev_real*cur_real) - DEQ(-prev_imag*cur_imag)
//            i = DEQ(prev_real*cur_imag) + DEQ(-prev_imag*cur_real)
//            register x<=r, y<=i; prev<=cur -> S_ISSUE.
//   S_ISSUE: demod_data_valid=1 for exactly this cycle -> S_WAIT.
//   S_WAIT : x,y held. On qarctan_done: latch angle -> S_GAIN. Otherwise stay (no timeout).
//   S_GAIN : res <= DEQ(GAIN*angle) -> S_OUT.
//   S_OUT  : if !out_full -> out_wr_en=1, out_dout=res -> S_IDLE. Otherwise stall with out_dout held.
//  Throughput: one sample per (5 + qarctan latency + full-stall) cycles. in_rd_en never asserts outside S_IDLE.
//  Timing: qarctan starts PRE_DIVISION one cycle after the pulse.
//   x,y must not change until the cycle after qarctan_done, because qarctan reads them combinationally in its output state.
//  qarctan_done outside S_WAIT is ignored.
//   demod_data_valid is never re-asserted before done; this avoids a double start, since qarctan samples a level in IDLE.
//  The first sample after reset uses prev=0, so x=y=0 and the output is DEQ(GAIN*qarctan(0,0)). This sample is emitted, not dropped.
//  in_empty may toggle freely. Samples are only consumed in S_IDLE, so none is lost or duplicated.
//  out_full high in S_OUT: hold indefinitely; no further pop occurs.
//  Reset mid-operation: all state is lost, including prev.
//   qarctan must be reset together with this block.
//   A done arriving after reset release, while in S_IDLE, is ignored.
//  Overflow: products wrap at 32 bits, matching the C reference model's int arithmetic. Saturation is not applied.
// STRUCTURE
//  Shared package fm_radio_pkg:
//   BITS, GAIN/QUAD constants, DEQUANTIZE/QUANTIZE_I functions, state_t enum for this FSM.
//  One sub-module, fm_cmul_conj: registered conjugate complex multiply with DEQ.
//   It is reusable by the pilot/stereo mixer.
//  Gain multiply and FSM stay inline.
// TESTING
//  Use a qarctan stub with fixed latency 40 and a programmable angle; also run with the real qarctan.
//  1. Single sample (1024,0) after reset; real qarctan.
//     Expect x=0, y=0, angle 0x648, and out_dout = DEQ(758*1608) = 1190.
//  2. Pair (1024,0) then (0,1024).
//     Expect the second x=0, y=1024, angle 1608 (pi/2), and out_dout = 1190.
//  3. Stub angle -1608.
//     Expect out_dout = -1190 (round toward zero; not -1191).
//  4. out_full held 20 cycles in S_OUT.
//     Expect out_wr_en=0, in_rd_en=0 throughout; exactly one write after release.
//  5. Stub asserts qarctan_done 5 cycles before the pulse, and x/y are monitored during S_WAIT.
//     Expect the early done to be ignored and x,y to be constant from pulse until the done cycle.
//  6. reset_n low during S_WAIT.
//     Expect all outputs 0 asynchronously and prev=0.
//     The next sample behaves as in scenario 1, and 1000 random samples match the C model bit-exactly.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio datapath.
//  - fixed-point constants (Q10 fraction, demod gain, quadrant angles)
//  - dequantize: arithmetic right shift by BITS with round toward zero
//  - quantize_i: integer to Q10
//  - state_t: state encoding of the discriminator front-end FSM
package fm_radio_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int BITS       = 10;

   // quad_rate / (2*pi*max_dev) = 0.7407 in Q10
   localparam int GAIN       = 758;

   // pi/4 and 3*pi/4 in Q10, as used by the qarctan stage
   localparam int QUAD1      = 804;
   localparam int QUAD3      = 2412;

   localparam logic signed [31:0] DEQ_BIAS = (32'sd1 <<< BITS) - 32'sd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MULT,
      S_ISSUE,
      S_WAIT,
      S_GAIN,
      S_OUT
   } state_t;

   // Negative values are biased by 2^BITS-1 before the shift so the result
   // truncates toward zero, matching C integer division.
   function automatic logic signed [31:0] dequantize(input logic signed [31:0] v);
      logic signed [31:0] t;
      t = v[31] ? (v + DEQ_BIAS) : v;
      return t >>> BITS;
   endfunction

   function automatic logic signed [31:0] quantize_i(input logic signed [31:0] v);
      return v <<< BITS;
   endfunction

endpackage

// File: rtl/fm_cmul_conj.sv
// Registered conjugate complex multiply: {re, im} <= a * conj(b), each
// partial product truncated to 32 bits and dequantized before summing.
// Ports:
//  clk, reset_n        clock, async active-low reset (clears re/im)
//  load                capture a new product this cycle; outputs hold otherwise
//  a_real, a_imag      current sample (Q10)
//  b_real, b_imag      conjugated operand, usually the previous sample (Q10)
//  re, im              registered product (Q10)
module fm_cmul_conj
   import fm_radio_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] a_real,
   input  logic [DATA_WIDTH-1:0] a_imag,
   input  logic [DATA_WIDTH-1:0] b_real,
   input  logic [DATA_WIDTH-1:0] b_imag,
   output logic [DATA_WIDTH-1:0] re,
   output logic [DATA_WIDTH-1:0] im
);

   logic signed [31:0] ar, ai, br, bi, nbi;
   logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [31:0] re_next, im_next;

   assign ar = a_real;
   assign ai = a_imag;
   assign br = b_real;
   assign bi = b_imag;

   // Written in the same term order as the C reference so that the 32-bit
   // wrap of each partial product is identical.
   always_comb begin
      nbi     = -bi;
      p_rr    = br * ar;
      p_ii    = nbi * ai;
      p_ri    = br * ai;
      p_ir    = nbi * ar;
      re_next = dequantize(p_rr) - dequantize(p_ii);
      im_next = dequantize(p_ri) + dequantize(p_ir);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         re <= '0;
         im <= '0;
      end else if (load) begin
         re <= re_next;
         im <= im_next;
      end
   end

endmodule

// File: rtl/fm_demod_front.sv
// FM discriminator front end. Pops one I/Q sample, forms cur*conj(prev),
// hands (x, y) to qarctan, scales the returned angle by the demod gain and
// pushes the result downstream.
// Ports:
//  clk, reset_n               clock, async active-low reset
//  in_empty, in_rd_en         upstream FIFO status / pop strobe
//  in_real, in_imag           current sample, valid while !in_empty
//  demod_data_valid           one-cycle start pulse to qarctan
//  x, y                       conjugate product, held until after qarctan_done
//  qarctan_data_out           angle from qarctan (Q10 radians)
//  qarctan_done               angle valid strobe
//  out_full, out_wr_en        downstream FIFO status / push strobe
//  out_dout                   demodulated sample (Q10)
//
// state   | meaning
// S_IDLE  | wait for a sample, pop it and latch cur
// S_MULT  | register cur*conj(prev) into x/y, prev <= cur
// S_ISSUE | single-cycle start pulse to qarctan
// S_WAIT  | hold x/y until qarctan_done, latch angle
// S_GAIN  | res <= dequantize(gain * angle)
// S_OUT   | push res when downstream has room
module fm_demod_front
   import fm_radio_pkg::*;
#(
   parameter logic signed [DATA_WIDTH-1:0] DEMOD_GAIN = GAIN
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   input  logic [DATA_WIDTH-1:0] in_real,
   input  logic [DATA_WIDTH-1:0] in_imag,
   output logic                  demod_data_valid,
   output logic [DATA_WIDTH-1:0] x,
   output logic [DATA_WIDTH-1:0] y,
   input  logic [DATA_WIDTH-1:0] qarctan_data_out,
   input  logic                  qarctan_done,
   input  logic                  out_full,
   output logic                  out_wr_en,
   output logic [DATA_WIDTH-1:0] out_dout
);

   state_t state, state_next;

   logic                         mul_load;
   logic [DATA_WIDTH-1:0]        cur_real, cur_imag;
   logic [DATA_WIDTH-1:0]        prev_real, prev_imag;
   logic signed [DATA_WIDTH-1:0] angle;
   logic signed [DATA_WIDTH-1:0] gain_prod;
   logic [DATA_WIDTH-1:0]        res;

   fm_cmul_conj u_cmul (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (mul_load),
      .a_real  (cur_real),
      .a_imag  (cur_imag),
      .b_real  (prev_real),
      .b_imag  (prev_imag),
      .re      (x),
      .im      (y)
   );

   assign gain_prod = DEMOD_GAIN * angle;
   assign out_dout  = res;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // in_rd_en is gated by reset_n so no pop is signalled while reset is held
   // with data waiting upstream.
   always_comb begin
      state_next       = state;
      in_rd_en         = 1'b0;
      demod_data_valid = 1'b0;
      out_wr_en        = 1'b0;
      mul_load         = 1'b0;
      case (state)
         S_IDLE: begin
            if (!in_empty && reset_n) begin
               in_rd_en   = 1'b1;
               state_next = S_MULT;
            end
         end
         S_MULT: begin
            mul_load   = 1'b1;
            state_next = S_ISSUE;
         end
         S_ISSUE: begin
            demod_data_valid = 1'b1;
            state_next       = S_WAIT;
         end
         S_WAIT: begin
            if (qarctan_done) begin
               state_next = S_GAIN;
            end
         end
         S_GAIN: begin
            state_next = S_OUT;
         end
         S_OUT: begin
            if (!out_full) begin
               out_wr_en  = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_real  <= '0;
         cur_imag  <= '0;
         prev_real <= '0;
         prev_imag <= '0;
         angle     <= '0;
         res       <= '0;
      end else begin
         if (in_rd_en) begin
            cur_real <= in_real;
            cur_imag <= in_imag;
         end
         if (mul_load) begin
            prev_real <= cur_real;
            prev_imag <= cur_imag;
         end
         if (state == S_WAIT && qarctan_done) begin
            angle <= qarctan_data_out;
         end
         if (state == S_GAIN) begin
            res <= dequantize(gain_prod);
         end
      end
   end

endmodule

// File: tb/tb_fm_demod_front.sv
module tb_fm_demod_front;

   localparam int QLAT = 40;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_empty = 1'b1;
   logic        in_rd_en;
   logic [31:0] in_real = '0;
   logic [31:0] in_imag = '0;
   logic        demod_data_valid;
   logic [31:0] x, y;
   logic [31:0] qarctan_data_out = '0;
   logic        qarctan_done = 1'b0;
   logic        out_full = 1'b0;
   logic        out_wr_en;
   logic [31:0] out_dout;

   always #5 clk = ~clk;

   fm_demod_front dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .in_empty         (in_empty),
      .in_rd_en         (in_rd_en),
      .in_real          (in_real),
      .in_imag          (in_imag),
      .demod_data_valid (demod_data_valid),
      .x                (x),
      .y                (y),
      .qarctan_data_out (qarctan_data_out),
      .qarctan_done     (qarctan_done),
      .out_full         (out_full),
      .out_wr_en        (out_wr_en),
      .out_dout         (out_dout)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- C reference model ----------------
   function automatic int deq(input int v);
      int t;
      t = (v < 0) ? v + 1023 : v;
      return t >>> 10;
   endfunction

   function automatic int qarctan_model(input int yv, input int xv);
      int abs_y, r, ang;
      abs_y = ((yv < 0) ? -yv : yv) + 1;
      if (xv >= 0) begin
         r   = ((xv - abs_y) * 1024) / (xv + abs_y);
         ang = 804 - deq(804 * r);
      end else begin
         r   = ((xv + abs_y) * 1024) / (abs_y - xv);
         ang = 2412 - deq(804 * r);
      end
      return (yv < 0) ? -ang : ang;
   endfunction

   // ---------------- upstream FIFO ----------------
   int q_re[$];
   int q_im[$];

   task automatic fifo_refresh();
      in_empty = (q_re.size() == 0);
      if (q_re.size() != 0) begin
         in_real = q_re[0];
         in_imag = q_im[0];
      end
   endtask

   task automatic fifo_push(input int r, input int i);
      q_re.push_back(r);
      q_im.push_back(i);
      fifo_refresh();
   endtask

   always @(posedge clk) begin : fifo_side
      logic popped;
      popped = in_rd_en;
      #1;
      if (popped && q_re.size() != 0) begin
         void'(q_re.pop_front());
         void'(q_im.pop_front());
      end
      fifo_refresh();
   end

   // ---------------- downstream monitor ----------------
   int   out_q[$];
   int   wr_count = 0;
   logic stall_watch = 1'b0;
   int   stall_viol = 0;

   always @(posedge clk) begin
      if (out_wr_en) begin
         out_q.push_back(out_dout);
         wr_count++;
      end
      if (stall_watch && (out_wr_en || in_rd_en)) stall_viol++;
   end

   // ---------------- qarctan stub ----------------
   int   stub_cnt = 0;
   logic stub_fixed = 1'b0;
   int   stub_angle = 0;
   int   cx = 0, cy = 0;
   int   starts = 0;
   int   dbl_start = 0;
   int   last_angle = 0;
   logic force_done = 1'b0;
   int   xy_changes = 0;

   always @(posedge clk) begin : stub
      logic p, rr;
      p  = demod_data_valid;
      rr = reset_n;
      #1;
      qarctan_done = 1'b0;
      if (!rr) begin
         stub_cnt = 0;
      end else if (p) begin
         if (stub_cnt != 0) dbl_start++;
         cx = x;
         cy = y;
         starts++;
         stub_cnt = QLAT;
      end else if (stub_cnt != 0) begin
         if (x !== cx || y !== cy) xy_changes++;
         stub_cnt--;
         if (stub_cnt == 0) begin
            last_angle       = stub_fixed ? stub_angle : qarctan_model(cy, cx);
            qarctan_data_out = last_angle;
            qarctan_done     = 1'b1;
         end
      end
      if (force_done) begin
         qarctan_data_out = 32'h1234;
         qarctan_done     = 1'b1;
         force_done       = 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_writes(input string tag, input int target);
      int n;
      n = 0;
      while (wr_count < target && n < 400) begin
         tick(1);
         n++;
      end
      chk(tag, wr_count, target);
   endtask

   function automatic int pop_out();
      if (out_q.size() != 0) return out_q.pop_front();
      return 32'hdeadbeef;
   endfunction

   task automatic run_sample(input string tag, input int r, input int i,
                             input int ex, input int ey, input int eout);
      int target;
      target = wr_count + 1;
      fifo_push(r, i);
      wait_writes({tag, "_wr"}, target);
      chk({tag, "_x"}, cx, ex);
      chk({tag, "_y"}, cy, ey);
      chk({tag, "_out"}, pop_out(), eout);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int base, n, k;
      int pr, pi, cr, ci, xr, yi;
      int exp_q[$];

      #23;
      chk("rst_rd_en", in_rd_en, 0);
      chk("rst_valid", demod_data_valid, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_dout", out_dout, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      #1 reset_n = 1'b1;
      tick(2);

      // 1: first sample after reset, prev=0
      run_sample("s1", 1024, 0, 0, 0, 1190);
      chk("s1_angle", last_angle, 1608);

      // 2: (0,1024) after (1024,0)
      run_sample("s2", 0, 1024, 0, 1024, 1190);
      chk("s2_angle", last_angle, 1608);

      // 3: negative angle rounds toward zero
      stub_fixed = 1'b1;
      stub_angle = -1608;
      run_sample("s3", 1024, 0, 0, -1024, -1190);

      // 4: downstream full for 20 cycles in S_OUT
      stub_angle = 100;
      out_full   = 1'b1;
      base       = wr_count;
      fifo_push(512, 512);
      tick(60);
      fifo_push(-301, 700);
      stall_watch = 1'b1;
      tick(20);
      stall_watch = 1'b0;
      chk("s4_stall_viol", stall_viol, 0);
      chk("s4_no_write", wr_count, base);
      out_full   = 1'b0;
      stub_angle = -300;
      tick(3);
      chk("s4_one_write", wr_count, base + 1);
      chk("s4_out", pop_out(), 74);
      chk("s4_x", cx, 512);
      chk("s4_y", cy, 512);
      wait_writes("s4b_wr", base + 2);
      chk("s4b_x", cx, 200);
      chk("s4b_y", cy, 500);
      chk("s4b_out", pop_out(), -222);

      // 5: stray done while idle, x/y stable through S_WAIT
      stub_angle = 200;
      xy_changes = 0;
      base       = wr_count;
      k          = starts;
      force_done = 1'b1;
      tick(4);
      chk("s5_early_ignored", wr_count, base);
      run_sample("s5", 100, -50, -63, -54, 148);
      chk("s5_xy_stable", xy_changes, 0);
      chk("s5_one_start", starts, k + 1);
      chk("s5_dbl_start", dbl_start, 0);

      // 6: reset during S_WAIT
      stub_fixed = 1'b0;
      k = starts;
      fifo_push(777, -333);
      n = 0;
      while (starts == k && n < 50) begin
         tick(1);
         n++;
      end
      chk("s6_started", starts, k + 1);
      tick(10);
      #1 reset_n = 1'b0;
      #1;
      chk("s6_rst_x", x, 0);
      chk("s6_rst_y", y, 0);
      chk("s6_rst_dout", out_dout, 0);
      chk("s6_rst_valid", demod_data_valid, 0);
      chk("s6_rst_wr_en", out_wr_en, 0);
      chk("s6_rst_rd_en", in_rd_en, 0);
      tick(2);
      out_q.delete();
      reset_n = 1'b1;
      tick(2);
      run_sample("s6", 1024, 0, 0, 0, 1190);

      // random stream against the C model, prev = (1024,0)
      pr = 1024;
      pi = 0;
      n  = 0;
      while (n < 1000) begin
         k = $urandom_range(1, 3);
         if (n + k > 1000) k = 1000 - n;
         base = wr_count;
         for (int j = 0; j < k; j++) begin
            cr = int'($urandom_range(0, 8191)) - 4096;
            ci = int'($urandom_range(0, 8191)) - 4096;
            xr = deq(pr * cr) - deq((-pi) * ci);
            yi = deq(pr * ci) + deq((-pi) * cr);
            exp_q.push_back(deq(758 * qarctan_model(yi, xr)));
            pr = cr;
            pi = ci;
            fifo_push(cr, ci);
         end
         wait_writes("rnd_wr", base + k);
         for (int j = 0; j < k; j++) begin
            chk("rnd_out", pop_out(), exp_q.pop_front());
         end
         n += k;
         tick($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
